// File: rtl/sevseg_frame_sequencer.sv
// Frame sequencer for the seven-segment effects datapath: steps the pattern
// mux select through a programmable loop, free-running or single-stepped.
module sevseg_frame_sequencer #(
   parameter int BASE_SHIFT = 16,
   parameter int PRESCALE_W = BASE_SHIFT + 7
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_mode,
   input  logic [2:0] i_rate,
   input  logic [3:0] i_last,
   input  logic       i_step,
   output logic [3:0] o_sel,
   output logic       o_dir,
   output logic       o_frame_strobe
);

   typedef enum logic [1:0] {
      MODE_FWD  = 2'b00,
      MODE_REV  = 2'b01,
      MODE_PING = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   mode_e                 mode;
   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] period_m1;
   logic                  tick;
   logic                  tick_q;
   logic                  step_prev_q;
   logic                  step_req;
   logic                  advance;
   logic [3:0]            sel_q;
   logic [3:0]            sel_d;
   logic                  dir_q;
   logic                  dir_d;
   logic                  strobe_q;

   assign mode = mode_e'(i_mode);

   always_comb begin
      period_m1 = (PRESCALE_W'(1) << (BASE_SHIFT + int'(i_rate)))
                - PRESCALE_W'(1);
   end

   // >= so that shrinking the period mid-count still wraps next clock
   assign tick     = i_en & (cnt_q >= period_m1);
   assign step_req = i_step & ~step_prev_q & ~i_en;
   assign advance  = tick_q | step_req;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         step_prev_q <= i_step;
         tick_q      <= tick;
         if (!i_en) begin
            cnt_q <= '0;
         end else if (tick) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
         end
      end
   end

   always_comb begin
      sel_d = sel_q;
      dir_d = dir_q;
      unique case (mode)
         MODE_FWD: begin
            sel_d = (sel_q >= i_last) ? 4'd0 : sel_q + 4'd1;
            dir_d = 1'b1;
         end
         MODE_REV: begin
            if (sel_q == 4'd0 || sel_q > i_last) begin
               sel_d = i_last;
            end else begin
               sel_d = sel_q - 4'd1;
            end
            dir_d = 1'b0;
         end
         MODE_PING: begin
            unique case (1'b1)
               (sel_q > i_last): begin
                  sel_d = i_last;
                  dir_d = 1'b0;
               end
               // a one-frame loop just flips direction in place
               (sel_q <= i_last && i_last == 4'd0): begin
                  dir_d = ~dir_q;
               end
               (sel_q <= i_last && i_last != 4'd0 && dir_q): begin
                  if (sel_q == i_last) begin
                     sel_d = i_last - 4'd1;
                     dir_d = 1'b0;
                  end else begin
                     sel_d = sel_q + 4'd1;
                  end
               end
               default: begin
                  if (sel_q == 4'd0) begin
                     sel_d = 4'd1;
                     dir_d = 1'b1;
                  end else begin
                     sel_d = sel_q - 4'd1;
                  end
               end
            endcase
         end
         default: begin
            sel_d = sel_q;
            dir_d = dir_q;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sel_q    <= 4'd0;
         dir_q    <= 1'b1;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= advance & (mode != MODE_HOLD);
         if (advance) begin
            sel_q <= sel_d;
            dir_q <= dir_d;
         end
      end
   end

   assign o_sel          = sel_q;
   assign o_dir          = dir_q;
   assign o_frame_strobe = strobe_q;

endmodule

// File: tb/tb_sevseg_frame_sequencer.sv
// Bench for sevseg_frame_sequencer: vector table, directed corner sequences
// and randomized stimulus against a frame-loop reference model.
module tb_sevseg_frame_sequencer;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [2:0] rate;
   logic [3:0] last;
   logic       step;
   logic [3:0] sel;
   logic       dir;
   logic       strobe;

   int checks = 0;
   int errors = 0;

   sevseg_frame_sequencer #(
      .BASE_SHIFT(2),
      .PRESCALE_W(9)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_en(en),
      .i_mode(mode),
      .i_rate(rate),
      .i_last(last),
      .i_step(step),
      .o_sel(sel),
      .o_dir(dir),
      .o_frame_strobe(strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: elapsed clocks in the current period, advance one clock after
   // a period completes, frame loop rules in plain integer arithmetic
   int m_elapsed;
   bit m_due;
   bit m_prev;
   int m_sel;
   bit m_dir;
   bit m_str;
   bit m_adv;
   int m_per;
   int m_lst;

   always @(posedge clk) begin
      if (rst) begin
         m_elapsed = 0;
         m_due     = 0;
         m_prev    = 0;
         m_sel     = 0;
         m_dir     = 1;
         m_str     = 0;
      end else begin
         m_adv = m_due || (step && !m_prev && !en);
         m_str = m_adv && (mode != 2'd3);
         m_lst = int'(last);
         if (m_adv) begin
            case (mode)
               2'd0: begin
                  m_sel = (m_sel > m_lst) ? 0 : (m_sel + 1) % (m_lst + 1);
                  m_dir = 1;
               end
               2'd1: begin
                  m_sel = (m_sel > m_lst) ? m_lst
                        : (m_sel + m_lst) % (m_lst + 1);
                  m_dir = 0;
               end
               2'd2: begin
                  if (m_sel > m_lst) begin
                     m_sel = m_lst;
                     m_dir = 0;
                  end else if (m_lst == 0) begin
                     m_dir = !m_dir;
                  end else if (m_dir) begin
                     if (m_sel == m_lst) begin
                        m_sel = m_lst - 1;
                        m_dir = 0;
                     end else begin
                        m_sel = m_sel + 1;
                     end
                  end else begin
                     if (m_sel == 0) begin
                        m_sel = 1;
                        m_dir = 1;
                     end else begin
                        m_sel = m_sel - 1;
                     end
                  end
               end
               default: ;
            endcase
         end
         m_per = 4 << int'(rate);
         m_due = 0;
         if (!en) begin
            m_elapsed = 0;
         end else if (m_elapsed + 1 >= m_per) begin
            m_due     = 1;
            m_elapsed = 0;
         end else begin
            m_elapsed = m_elapsed + 1;
         end
         m_prev = step;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   int strobes;

   task automatic pulse;
      step = 1'b1;
      cyc();
      if (strobe) strobes++;
      step = 1'b0;
      cyc();
      if (strobe) strobes++;
   endtask

   typedef struct {
      bit       rst;
      bit       en;
      bit [1:0] mode;
      bit [3:0] last;
      bit       step;
      bit [3:0] sel;
      bit       dir;
      bit       str;
   } vec_t;

   vec_t tv[23];

   int pp_sel[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
   int pp_dir[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
   int rv_sel[8] = '{5, 4, 3, 2, 1, 0, 5, 4};

   initial begin
      int j;
      int held;
      bit seen;

      rst  = 1'b1;
      en   = 1'b0;
      mode = 2'd0;
      rate = 3'd0;
      last = 4'd3;
      step = 1'b0;

      //           rst en md lst stp  sel dir str
      tv[0]  = '{1, 0, 0, 3, 0, 0, 1, 0};
      tv[1]  = '{0, 0, 0, 3, 1, 1, 1, 1};
      tv[2]  = '{0, 0, 0, 3, 1, 1, 1, 0};
      tv[3]  = '{0, 0, 0, 3, 0, 1, 1, 0};
      tv[4]  = '{0, 0, 0, 3, 1, 2, 1, 1};
      tv[5]  = '{0, 0, 1, 3, 0, 2, 1, 0};
      tv[6]  = '{0, 0, 1, 3, 1, 1, 0, 1};
      tv[7]  = '{0, 0, 1, 3, 0, 1, 0, 0};
      tv[8]  = '{0, 0, 2, 3, 1, 0, 0, 1};
      tv[9]  = '{0, 0, 2, 3, 0, 0, 0, 0};
      tv[10] = '{0, 0, 2, 3, 1, 1, 1, 1};
      tv[11] = '{0, 0, 2, 1, 0, 1, 1, 0};
      tv[12] = '{0, 0, 2, 1, 1, 0, 0, 1};
      tv[13] = '{0, 0, 3, 1, 0, 0, 0, 0};
      tv[14] = '{0, 0, 3, 1, 1, 0, 0, 0};
      tv[15] = '{0, 0, 2, 0, 0, 0, 0, 0};
      tv[16] = '{0, 0, 2, 0, 1, 0, 1, 1};
      tv[17] = '{0, 0, 2, 0, 0, 0, 1, 0};
      tv[18] = '{0, 0, 2, 0, 1, 0, 0, 1};
      tv[19] = '{0, 0, 0, 3, 0, 0, 0, 0};
      tv[20] = '{0, 0, 0, 3, 1, 1, 1, 1};
      tv[21] = '{0, 1, 0, 3, 1, 1, 1, 0};
      tv[22] = '{1, 1, 0, 3, 0, 0, 1, 0};

      for (int i = 0; i < 23; i++) begin
         rst  = tv[i].rst;
         en   = tv[i].en;
         mode = tv[i].mode;
         last = tv[i].last;
         step = tv[i].step;
         cyc();
         chk($sformatf("tv%0d_sel", i), sel, tv[i].sel);
         chk($sformatf("tv%0d_dir", i), dir, tv[i].dir);
         chk($sformatf("tv%0d_strobe", i), strobe, tv[i].str);
      end

      // free-run forward, period 4
      do_reset();
      en = 1'b1; mode = 2'd0; rate = 3'd0; last = 4'd3; step = 1'b0;
      for (int k = 0; k < 24; k++) begin
         cyc();
         chk($sformatf("fwd_k%0d_sel", k), sel, (k / 4) % 4);
         chk($sformatf("fwd_k%0d_strobe", k), strobe,
             (k >= 4 && k % 4 == 0) ? 1 : 0);
      end

      // ping-pong, period 8
      do_reset();
      en = 1'b1; mode = 2'd2; rate = 3'd1; last = 4'd3;
      for (int k = 0; k <= 56; k++) begin
         cyc();
         j = k / 8;
         chk($sformatf("pp_k%0d_sel", k), sel, pp_sel[j]);
         chk($sformatf("pp_k%0d_dir", k), dir, pp_dir[j]);
         chk($sformatf("pp_k%0d_strobe", k), strobe,
             (k >= 8 && k % 8 == 0) ? 1 : 0);
      end

      // reverse via manual steps, then shrink the loop
      do_reset();
      en = 1'b0; mode = 2'd1; rate = 3'd0; last = 4'd5;
      for (int k = 0; k < 8; k++) begin
         strobes = 0;
         pulse();
         chk($sformatf("rev_%0d_sel", k), sel, rv_sel[k]);
         chk($sformatf("rev_%0d_dir", k), dir, 0);
         chk($sformatf("rev_%0d_strobes", k), strobes, 1);
      end
      last = 4'd2;
      pulse();
      chk("rev_shrink_sel", sel, 2);

      // manual pulses, held step, then steps while enabled
      do_reset();
      en = 1'b0; mode = 2'd0; last = 4'd15;
      strobes = 0;
      for (int k = 0; k < 3; k++) pulse();
      chk("step3_sel", sel, 3);
      step = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (strobe) strobes++;
      end
      step = 1'b0;
      cyc();
      if (strobe) strobes++;
      chk("step_hold_sel", sel, 4);
      chk("step_hold_strobes", strobes, 4);
      en = 1'b1;
      strobes = 0;
      for (int k = 0; k < 3; k++) begin
         step = (k % 2 == 0);
         cyc();
         if (strobe) strobes++;
      end
      chk("step_en_sel", sel, 4);
      chk("step_en_strobes", strobes, 0);
      step = 1'b0;
      en = 1'b0;

      // hold mode with prescaler running
      do_reset();
      en = 1'b1; mode = 2'd0; rate = 3'd0; last = 4'd9;
      for (int k = 0; k < 10; k++) cyc();
      chk("hold_pre_sel", sel, 2);
      mode = 2'd3;
      held = int'(sel);
      strobes = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (strobe) strobes++;
         if (sel != 4'(held)) strobes += 100;
      end
      chk("hold_strobes", strobes, 0);
      chk("hold_sel", sel, held);
      mode = 2'd0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         cyc();
         if (strobe) seen = 1'b1;
      end
      chk("hold_resume_seen", seen, 1);
      chk("hold_resume_sel", sel, held + 1);

      // reset mid-run from sel=7, dir=0
      do_reset();
      en = 1'b0; mode = 2'd1; last = 4'd7;
      pulse();
      chk("rst_pre_sel", sel, 7);
      chk("rst_pre_dir", dir, 0);
      en = 1'b1; mode = 2'd0; rate = 3'd0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_sel", sel, 0);
      chk("rst_dir", dir, 1);
      chk("rst_strobe", strobe, 0);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk($sformatf("rst_k%0d_sel", k), sel, (k == 5) ? 1 : 0);
         chk($sformatf("rst_k%0d_strobe", k), strobe, (k == 5) ? 1 : 0);
      end

      // randomized run against the reference model
      do_reset();
      en = 1'b1; mode = 2'd0; rate = 3'd0; last = 4'd5;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) rate = 3'($urandom_range(0, 2));
         if ($urandom_range(0, 19) == 0) last = 4'($urandom_range(0, 15));
         step = 1'($urandom_range(0, 1));
         rst  = ($urandom_range(0, 299) == 0);
         cyc();
         chk($sformatf("rnd%0d_sel", k), sel, m_sel);
         chk($sformatf("rnd%0d_dir", k), dir, m_dir);
         chk($sformatf("rnd%0d_strobe", k), strobe, m_str);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sevseg_frame_sequencer.md
# sevseg_frame_sequencer

Frame sequencer driving the 4-bit select of the 16-entry, 7-bit segment-pattern mux in the seven-segment effects datapath. It steps the select through a programmable loop of frames, either free-running at a prescaled rate or manually single-stepped. Supported modes are forward, reverse, ping-pong and hold. A one-cycle strobe marks every frame change so downstream logic (display latch, effect counters) can resynchronise.

## Interface
- BASE_SHIFT, 16, log2 of the frame period at i_rate=0; period = 2^(BASE_SHIFT+i_rate) clocks
- PRESCALE_W, BASE_SHIFT+7, prescaler counter width (must hold 2^(BASE_SHIFT+7)-1)

Ports:
- i_clk  in  1  single clock, all state rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  1 = free-run from prescaler; 0 = stopped, manual step allowed
- i_mode  in  2  00 forward, 01 reverse, 10 ping-pong, 11 hold
- i_rate  in  3  frame period select, period = 2^(BASE_SHIFT+i_rate) clocks
- i_last  in  4  index of last frame in loop (loop = frames 0..i_last)
- i_step  in  1  manual advance request, rising-edge detected, honoured only when i_en=0
- o_sel  out  4  frame index to mux select
- o_dir  out  1  ping-pong direction, 1 = up, 0 = down
- o_frame_strobe  out  1  one-cycle pulse, high in the cycle o_sel holds a newly loaded value

## Operation
- Reset values: o_sel=0, o_dir=1, o_frame_strobe=0, prescaler=0, step-edge register=0. Reset overrides every other input in the same cycle.
- Prescaler: while i_en=1, increments each clock. At count == period-1 it wraps to 0 and generates a tick. While i_en=0 it is held at 0.
- i_rate changes take effect immediately. If the count already exceeds the new period-1, the next compare uses >=, so a tick fires on the next clock.
- Step: a step-edge register holds i_step from the previous cycle. Step request = i_step & ~prev & ~i_en. i_step is ignored entirely while i_en=1, though prev still tracks it.
- Advance event = tick or step request. On advance, i_mode and i_last are sampled; changes between advances have no effect until the next advance.
- Forward: o_sel = (o_sel >= i_last) ? 0 : o_sel+1. Sets o_dir=1.
- Reverse: o_sel = (o_sel == 0 or o_sel > i_last) ? i_last : o_sel-1. Sets o_dir=0.
- Ping-pong, o_dir=1:
  - o_sel > i_last: o_sel=i_last, o_dir=0.
  - o_sel == i_last: o_sel=i_last-1, o_dir=0.
  - otherwise o_sel+1.
- Ping-pong, o_dir=0:
  - o_sel > i_last: o_sel=i_last.
  - o_sel == 0: o_sel=1, o_dir=1.
  - otherwise o_sel-1.
- Ping-pong with i_last=0: o_sel stays 0, o_dir toggles.
- Hold: o_sel and o_dir unchanged, no strobe. The prescaler keeps running.
- o_frame_strobe: asserted for exactly the one cycle after an advance in modes 00/01/10, even when the new o_sel equals the old one (i_last=0).
- All arithmetic is 4-bit unsigned. No out-of-range o_sel can result from an advance.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Free-run: with i_en first sampled high at edge E0, the first advance is loaded at edge E0+period. Thereafter o_sel changes every period clocks.
- Step: i_step rises and is sampled at edge E (i_en=0). o_sel/strobe are updated at E, visible in the following cycle. Holding i_step high produces one advance only.
- Dropping i_en mid-period clears the prescaler. Re-enabling restarts a full period.
- Reset mid-run: outputs return to reset values at the next edge, and the prescaler restarts from 0.

## Test plan
- BASE_SHIFT=2, i_rate=0, i_mode=00, i_last=3, i_en=1 after reset -> o_sel 0,1,2,3,0,1 changing every 4 clocks; strobe high one cycle per change.
- i_mode=10, i_last=3, i_rate=1 -> o_sel 1,2,3,2,1,0,1 every 8 clocks; o_dir falls on the move 3->2 and rises on the move 0->1.
- i_mode=01, i_last=5, start o_sel=0 -> 5,4,3,2,1,0,5; then i_last set to 2 while o_sel=4 -> next advance loads 2.
- i_en=0, pulse i_step 3 times, then hold i_step high 10 clocks (mode 00, i_last=15) -> o_sel 1,2,3,4 with exactly 4 strobes; step pulses with i_en=1 cause no extra advance.
- i_mode=11 with i_en=1 for 40 clocks -> o_sel constant, strobe never asserted; switching to 00 -> advances from the held value.
- Assert i_rst for 1 cycle while o_sel=7, o_dir=0 -> next cycle o_sel=0, o_dir=1, strobe=0; first advance again one full period later.
